// File: rtl/stage_sequencer_if.sv
// Handshake/strobe bundle between the stage sequencer and the core datapath.
// Perf counters (cycles, stall_cycles) are present only when STAGE_SEQ_PERF_EN is defined.
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             rwmem;
    logic             mem_ack;
    logic             halt;
    logic             en_ft;
    logic             en_dc;
    logic             en_ex;
    logic             en_ma;
    logic             en_wb;
    logic             mem_req;
    logic [2:0]       stage;
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] retired;
`ifdef STAGE_SEQ_PERF_EN
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] stall_cycles;
`endif

    modport master (
`ifdef STAGE_SEQ_PERF_EN
        output cycles,
        output stall_cycles,
`endif
        input  rwmem,
        input  mem_ack,
        input  halt,
        output en_ft,
        output en_dc,
        output en_ex,
        output en_ma,
        output en_wb,
        output mem_req,
        output stage,
        output halted,
        output mem_err,
        output retired
    );

    modport slave (
`ifdef STAGE_SEQ_PERF_EN
        input  cycles,
        input  stall_cycles,
`endif
        output rwmem,
        output mem_ack,
        output halt,
        input  en_ft,
        input  en_dc,
        input  en_ex,
        input  en_ma,
        input  en_wb,
        input  mem_req,
        input  stage,
        input  halted,
        input  mem_err,
        input  retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// Stage-enable sequencer for the multi-cycle RV32 core: one-cycle strobes FT->DC->EX->[MA]->WB.
// Optional perf counters are enabled by defining STAGE_SEQ_PERF_EN.
module stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    stage_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_FT   = 3'd0,
        ST_DC   = 3'd1,
        ST_EX   = 3'd2,
        ST_MA   = 3'd3,
        ST_WB   = 3'd4,
        ST_IDLE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retired;
    logic              mem_err;
    logic              timeout_hit;

    // The limit is hit on the last unacknowledged MA cycle; an ack in that cycle still wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) && !bus.mem_ack
                         && (32'(wait_cnt) == 32'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_FT;
        case (state)
            ST_FT:   next_state = ST_DC;
            ST_DC:   next_state = ST_EX;
            ST_EX:   next_state = bus.rwmem ? ST_MA : ST_WB;
            ST_MA: begin
                if (bus.mem_ack) begin
                    next_state = ST_WB;
                end else if (timeout_hit) begin
                    next_state = ST_ERR;
                end else begin
                    next_state = ST_MA;
                end
            end
            ST_WB:   next_state = bus.halt ? ST_IDLE : ST_FT;
            ST_IDLE: next_state = bus.halt ? ST_IDLE : ST_FT;
            ST_ERR:  next_state = ST_ERR;
            default: next_state = ST_FT;
        endcase
    end

    always_comb begin
        bus.en_ft   = 1'b0;
        bus.en_dc   = 1'b0;
        bus.en_ex   = 1'b0;
        bus.en_ma   = 1'b0;
        bus.en_wb   = 1'b0;
        bus.mem_req = 1'b0;
        bus.halted  = 1'b0;
        case (state)
            ST_FT:   bus.en_ft = 1'b1;
            ST_DC:   bus.en_dc = 1'b1;
            ST_EX:   bus.en_ex = 1'b1;
            ST_MA: begin
                bus.mem_req = 1'b1;
                bus.en_ma   = bus.mem_ack;
            end
            ST_WB:   bus.en_wb = 1'b1;
            ST_IDLE: bus.halted = 1'b1;
            ST_ERR:  bus.halted = 1'b1;
            default: bus.halted = 1'b0;
        endcase
    end

    // Entry into MA always comes from EX, so clearing outside MA gives a fresh count per access.
    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_MA) begin
            wait_cnt <= '0;
        end else if (!bus.mem_ack && MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired <= '0;
            mem_err <= 1'b0;
        end else begin
            if (state == ST_WB) begin
                retired <= retired + 1'b1;
            end
            if (state == ST_MA && next_state == ST_ERR) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign bus.stage   = state;
    assign bus.retired = retired;
    assign bus.mem_err = mem_err;

`ifdef STAGE_SEQ_PERF_EN
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycles       <= '0;
            stall_cycles <= '0;
        end else begin
            cycles <= cycles + 1'b1;
            if (state == ST_MA && !bus.mem_ack) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign bus.cycles       = cycles;
    assign bus.stall_cycles = stall_cycles;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: a per-instruction plan is expanded into expected
// per-cycle outputs, then replayed against the DUT (perf outputs checked if STAGE_SEQ_PERF_EN).
module tb_stage_sequencer;
    localparam int CNT_W       = 6;
    localparam int MEM_TIMEOUT = 4;
    localparam int MASK        = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stage_sequencer_if #(.CNT_W(CNT_W)) bus();

    stage_sequencer #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit       rst_n;
        bit       rwmem;
        bit       mem_ack;
        bit       halt;
        bit       chk;
        int       stage;
        bit [4:0] en;
        bit       req;
        bit       halted;
        bit       err;
        int       ret;
        int       cyc;
        int       stall;
    } cyc_t;

    cyc_t plan[$];
    int   m_ret;
    int   m_cyc;
    int   m_stall;
    bit   m_err;
    int   n_checks;
    int   n_fail;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs for one cycle follow directly from the stage being occupied.
    task automatic push_cycle(int st, bit rw, bit ak, bit hl, bit rn, bit chk);
        cyc_t c;
        if (st == 6) m_err = 1'b1;
        c.rst_n   = rn;
        c.rwmem   = rw;
        c.mem_ack = ak;
        c.halt    = hl;
        c.chk     = chk;
        c.stage   = st;
        c.en      = 5'b0;
        if (st >= 0 && st <= 2) c.en[st] = 1'b1;
        if (st == 3) c.en[3] = ak;
        if (st == 4) c.en[4] = 1'b1;
        c.req     = (st == 3);
        c.halted  = (st == 5 || st == 6);
        c.err     = m_err;
        c.ret     = m_ret;
        c.cyc     = m_cyc;
        c.stall   = m_stall;
        plan.push_back(c);
        if (!rn) begin
            m_ret   = 0;
            m_cyc   = 0;
            m_stall = 0;
            m_err   = 1'b0;
        end else begin
            m_cyc = (m_cyc + 1) & MASK;
            if (st == 3 && !ak) m_stall = (m_stall + 1) & MASK;
            if (st == 4) m_ret = (m_ret + 1) & MASK;
        end
    endtask

    // One instruction: r=memory op, w=wait cycles before ack, h=halt at WB, rst_at=cycle offset of a reset.
    task automatic gen_instr(bit r, int w, bit h, int idle_n, int rst_at);
        int st_q[$];
        bit rw_q[$];
        bit ak_q[$];
        bit hl_q[$];
        bit to;
        int n_ma;
        int last;
        to = r && (w >= MEM_TIMEOUT);
        for (int k = 0; k < 2; k++) begin
            st_q.push_back(k); rw_q.push_back(rb()); ak_q.push_back(rb()); hl_q.push_back(rb());
        end
        st_q.push_back(2); rw_q.push_back(r); ak_q.push_back(rb()); hl_q.push_back(rb());
        if (r) begin
            n_ma = to ? MEM_TIMEOUT : w + 1;
            for (int k = 0; k < n_ma; k++) begin
                st_q.push_back(3); rw_q.push_back(rb());
                ak_q.push_back(!to && k == w); hl_q.push_back(rb());
            end
        end
        if (to) begin
            for (int k = 0; k < 3; k++) begin
                st_q.push_back(6); rw_q.push_back(rb()); ak_q.push_back(rb()); hl_q.push_back(rb());
            end
            last = st_q.size() - 1;
            if (rst_at < 0 || rst_at > last) rst_at = last;
        end else begin
            st_q.push_back(4); rw_q.push_back(rb()); ak_q.push_back(rb()); hl_q.push_back(h);
            if (h) begin
                for (int k = 0; k < idle_n; k++) begin
                    st_q.push_back(5); rw_q.push_back(rb()); ak_q.push_back(rb());
                    hl_q.push_back(k != idle_n - 1);
                end
            end
        end
        for (int i = 0; i < st_q.size(); i++) begin
            push_cycle(st_q[i], rw_q[i], ak_q[i], hl_q[i], i != rst_at, 1'b1);
            if (i == rst_at) break;
        end
    endtask

    task automatic apply_stimulus(int i);
        rst_n       = plan[i].rst_n;
        bus.rwmem   = plan[i].rwmem;
        bus.mem_ack = plan[i].mem_ack;
        bus.halt    = plan[i].halt;
    endtask

    task automatic check_output(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        int r;
        int w;
        int h;
        int idle;
        int ra;
        n_checks    = 0;
        n_fail      = 0;
        bus.rwmem   = 1'b0;
        bus.mem_ack = 1'b0;
        bus.halt    = 1'b0;

        push_cycle(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) gen_instr(1'b0, 0, 1'b0, 1, -1);
        gen_instr(1'b1, 2, 1'b0, 1, -1);
        gen_instr(1'b0, 0, 1'b1, 3, -1);
        gen_instr(1'b1, 100, 1'b0, 1, -1);
        gen_instr(1'b1, 9, 1'b0, 1, 5);
        for (int n = 0; n < 70; n++) gen_instr(1'b0, 0, 1'b0, 1, -1);
        for (int n = 0; n < 150; n++) begin
            r    = int'(rb());
            w    = int'($urandom_range(0, 5));
            h    = ($urandom_range(0, 4) == 0) ? 1 : 0;
            idle = int'($urandom_range(1, 3));
            ra   = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 8)) : -1;
            gen_instr(r[0], w, h[0], idle, ra);
        end
        gen_instr(1'b0, 0, 1'b0, 1, -1);

        fork
            begin
                for (int i = 0; i < plan.size(); i++) begin
                    @(posedge clk);
                    #1;
                    apply_stimulus(i);
                end
            end
            begin
                for (int j = 0; j < plan.size(); j++) begin
                    @(negedge clk);
                    if (plan[j].chk) begin
                        check_output("stage", j, 32'(bus.stage), 32'(plan[j].stage));
                        check_output("strobes", j,
                            32'({bus.en_wb, bus.en_ma, bus.en_ex, bus.en_dc, bus.en_ft}), 32'(plan[j].en));
                        check_output("mem_req", j, 32'(bus.mem_req), 32'(plan[j].req));
                        check_output("halted", j, 32'(bus.halted), 32'(plan[j].halted));
                        check_output("mem_err", j, 32'(bus.mem_err), 32'(plan[j].err));
                        check_output("retired", j, 32'(bus.retired), 32'(plan[j].ret));
`ifdef STAGE_SEQ_PERF_EN
                        check_output("cycles", j, 32'(bus.cycles), 32'(plan[j].cyc));
                        check_output("stall_cycles", j, 32'(bus.stall_cycles), 32'(plan[j].stall));
`endif
                    end
                    case (j)
                        13: begin
                            check_output("lit_retired_3", j, 32'(bus.retired), 32'd3);
                            check_output("lit_ft_after_3", j, 32'(bus.en_ft), 32'd1);
                        end
                        17: begin
                            check_output("lit_ma_wait_req", j, 32'(bus.mem_req), 32'd1);
                            check_output("lit_ma_wait_noma", j, 32'(bus.en_ma), 32'd0);
                        end
                        18: check_output("lit_ma_ack", j, 32'(bus.en_ma), 32'd1);
                        19: check_output("lit_wb_after_ma", j, 32'(bus.en_wb), 32'd1);
                        20: begin
                            check_output("lit_retired_4", j, 32'(bus.retired), 32'd4);
`ifdef STAGE_SEQ_PERF_EN
                            check_output("lit_cycles_19", j, 32'(bus.cycles), 32'd19);
                            check_output("lit_stall_2", j, 32'(bus.stall_cycles), 32'd2);
`endif
                        end
                        25: begin
                            check_output("lit_idle_halted", j, 32'(bus.halted), 32'd1);
                            check_output("lit_idle_nostrobe", j,
                                32'({bus.en_wb, bus.en_ma, bus.en_ex, bus.en_dc, bus.en_ft}), 32'd0);
                        end
                        27: begin
                            check_output("lit_resume_ft", j, 32'(bus.en_ft), 32'd1);
                            check_output("lit_retired_5", j, 32'(bus.retired), 32'd5);
                        end
                        34: begin
                            check_output("lit_err_stage", j, 32'(bus.stage), 32'd6);
                            check_output("lit_err_flag", j, 32'(bus.mem_err), 32'd1);
                            check_output("lit_err_noreq", j, 32'(bus.mem_req), 32'd0);
                            check_output("lit_err_halted", j, 32'(bus.halted), 32'd1);
                        end
                        37: begin
                            check_output("lit_err_reset_stage", j, 32'(bus.stage), 32'd0);
                            check_output("lit_err_reset_flag", j, 32'(bus.mem_err), 32'd0);
                            check_output("lit_err_reset_ret", j, 32'(bus.retired), 32'd0);
                        end
                        42: check_output("lit_ma_rst_req", j, 32'(bus.mem_req), 32'd1);
                        43: begin
                            check_output("lit_ma_rst_stage", j, 32'(bus.stage), 32'd0);
                            check_output("lit_ma_rst_ret", j, 32'(bus.retired), 32'd0);
                            check_output("lit_ma_rst_req0", j, 32'(bus.mem_req), 32'd0);
                        end
                        298: check_output("lit_ret_max", j, 32'(bus.retired), 32'd63);
                        299: check_output("lit_ret_wrap", j, 32'(bus.retired), 32'd0);
                        default: ;
                    endcase
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
